// File: rtl/mb_pkg.sv
// Shared constants and types for the mother_board integration slice.
package mb_pkg;

  localparam int unsigned DEF_IMEM_WORDS = 1024;
  localparam int unsigned DEF_DMEM_WORDS = 1024;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] MMIO_IRQ_ADDR  = 32'hFFFF_0000;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam int unsigned IRQ_W          = 5;

  // Subset of MIPS major opcodes decoded by the core
  typedef enum logic [5:0] {
    OP_ADDI = 6'h08,
    OP_LUI  = 6'h0F,
    OP_LW   = 6'h23,
    OP_SB   = 6'h28,
    OP_SW   = 6'h2B
  } opcode_t;

  // Data-side request from the core to the board
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } dmem_req_t;

endpackage

// File: rtl/mother_board_mem.sv
// Word memories with byte-enable writes and combinational reads.
// Out-of-range accesses read as 0 (data) or NOP (instructions); writes there are dropped.
module mb_imem
  import mb_pkg::*;
#(
  parameter int unsigned WORDS = DEF_IMEM_WORDS
) (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_c
);

  localparam int unsigned AW = $clog2(WORDS);

  logic [31:0]   inst_array [WORDS];
  logic [AW-1:0] idx;
  logic          in_range;
  logic          unused_lsb;

  assign idx        = addr[AW+1:2];
  assign in_range   = (addr[31:AW+2] == '0);
  assign rdata_c    = in_range ? inst_array[idx] : NOP_INSTR;
  assign unused_lsb = ^addr[1:0];

  // Byte-lane write port (tied off by the board; contents come from preload)
  always_ff @(posedge clk) begin
    if (we && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) inst_array[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

module mb_dmem
  import mb_pkg::*;
#(
  parameter int unsigned WORDS = DEF_DMEM_WORDS
) (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_c
);

  localparam int unsigned AW = $clog2(WORDS);

  logic [31:0]   data_array [WORDS];
  logic [AW-1:0] idx;
  logic          in_range;
  logic          unused_lsb;

  assign idx        = addr[AW+1:2];
  assign in_range   = (addr[31:AW+2] == '0);
  assign rdata_c    = in_range ? data_array[idx] : 32'h0000_0000;
  assign unused_lsb = ^addr[1:0];

  // Byte-lane write; same-cycle read still sees the old word
  always_ff @(posedge clk) begin
    if (we && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) data_array[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/mother_board_sync.sv
// Two-flop synchronizer with async active-low clear; used for reset and irq lines.
module mb_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture; both stages clear immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/soc.sv
// Minimal in-order stand-in for the CPU wrapper: soc -> core0 -> gpr_inst.
// Two stages (fetch, execute); execute reads/writes the register file and data port directly.
// This stand-in takes no exceptions; the interrupt vector is only presented at its port.
module gpr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1_c,
  output logic [31:0] rd2_c
);

  logic [31:0] array_reg [32];

  assign rd1_c = array_reg[ra1];
  assign rd2_c = array_reg[ra2];

  // Register file; $0 is never written so it reads as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) array_reg[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      array_reg[wa] <= wd;
    end
  end

endmodule

module core
  import mb_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IRQ_W-1:0] irq,
  output logic [31:0]      fetch_addr,
  input  logic [31:0]      fetch_instr,
  output dmem_req_t        dreq_c,
  input  logic [31:0]      drdata,
  output logic [31:0]      exe_pc_out,
  output logic [31:0]      exe_instr
);

  logic [31:0] pc;
  logic [31:0] rs_val, rt_val, se_imm, ea;
  logic        wb_en;
  logic [31:0] wb_data;
  opcode_t     op;
  logic        unused_irq;

  assign fetch_addr = pc;
  assign op         = opcode_t'(exe_instr[31:26]);
  assign se_imm     = {{16{exe_instr[15]}}, exe_instr[15:0]};
  assign ea         = rs_val + se_imm;
  assign unused_irq = ^irq;

  // Fetch PC and fetch->execute pipeline register; reset flushes to NOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      exe_pc_out <= '0;
      exe_instr  <= NOP_INSTR;
    end else begin
      pc         <= pc + 32'd4;
      exe_pc_out <= pc;
      exe_instr  <= fetch_instr;
    end
  end

  // Execute-stage decode: writeback value and data-port request
  always_comb begin
    dreq_c  = '0;
    wb_en   = 1'b0;
    wb_data = '0;
    case (op)
      OP_ADDI: begin
        wb_en   = 1'b1;
        wb_data = ea;
      end
      OP_LUI: begin
        wb_en   = 1'b1;
        wb_data = {exe_instr[15:0], 16'h0000};
      end
      OP_LW: begin
        dreq_c.addr = ea;
        wb_en       = 1'b1;
        wb_data     = drdata;
      end
      OP_SW: begin
        dreq_c.addr  = ea;
        dreq_c.we    = 1'b1;
        dreq_c.be    = 4'hF;
        dreq_c.wdata = rt_val;
      end
      OP_SB: begin
        dreq_c.addr  = ea;
        dreq_c.we    = 1'b1;
        dreq_c.be    = 4'(4'b0001 << ea[1:0]);
        dreq_c.wdata = {4{rt_val[7:0]}};
      end
      default: ;
    endcase
  end

  gpr gpr_inst (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (exe_instr[25:21]),
    .ra2   (exe_instr[20:16]),
    .we    (wb_en),
    .wa    (exe_instr[20:16]),
    .wd    (wb_data),
    .rd1_c (rs_val),
    .rd2_c (rt_val)
  );

endmodule

module soc
  import mb_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IRQ_W-1:0] irq,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output dmem_req_t        dreq_c,
  input  logic [31:0]      drdata,
  output logic [31:0]      exe_pc,
  output logic [31:0]      exe_instr
);

  core #(.RESET_PC(RESET_PC)) core0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq         (irq),
    .fetch_addr  (imem_addr),
    .fetch_instr (imem_rdata),
    .dreq_c      (dreq_c),
    .drdata      (drdata),
    .exe_pc_out  (exe_pc),
    .exe_instr   (exe_instr)
  );

endmodule

// File: rtl/mother_board.sv
// Board integration: reset/irq conditioning, IMEM, DMEM with IRQ MMIO, CPU wrapper.
// Optional debug ports enabled by MOTHERBOARD_DEBUG_EN.
module mother_board
  import mb_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = DEF_IMEM_WORDS,
  parameter int unsigned DMEM_WORDS = DEF_DMEM_WORDS,
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IRQ_W-1:0] i_interruption
`ifdef MOTHERBOARD_DEBUG_EN
  ,
  output logic [31:0]      o_debug_pc,
  output logic [31:0]      o_debug_instr
`endif
);

  logic             rst_n;
  logic [IRQ_W-1:0] irq_sync;
  logic [31:0]      imem_addr, imem_rdata;
  logic [31:0]      dmem_rdata, core_rdata;
  logic [31:0]      dbg_pc, dbg_instr;
  dmem_req_t        dreq;

  // Reset asserts at once, releases two clocks after the pin rises
  mb_sync #(.W(1)) rst_sync_inst (
    .clk   (clk),
    .rst_n (reset),
    .d     (1'b1),
    .q     (rst_n)
  );

  // Interrupt lines synchronized as levels
  mb_sync #(.W(IRQ_W)) irq_sync_inst (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (i_interruption),
    .q     (irq_sync)
  );

  soc #(.RESET_PC(RESET_PC)) soc (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq        (irq_sync),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dreq_c     (dreq),
    .drdata     (core_rdata),
    .exe_pc     (dbg_pc),
    .exe_instr  (dbg_instr)
  );

  mb_imem #(.WORDS(IMEM_WORDS)) imem_inst (
    .clk     (clk),
    .we      (1'b0),
    .be      (4'h0),
    .addr    (imem_addr),
    .wdata   (32'h0000_0000),
    .rdata_c (imem_rdata)
  );

  mb_dmem #(.WORDS(DMEM_WORDS)) dmem_inst (
    .clk     (clk),
    .we      (dreq.we),
    .be      (dreq.be),
    .addr    (dreq.addr),
    .wdata   (dreq.wdata),
    .rdata_c (dmem_rdata)
  );

  // IRQ status word overlays the data read path; writes there fall out of DMEM range
  assign core_rdata = (dreq.addr == MMIO_IRQ_ADDR) ? {27'b0, irq_sync} : dmem_rdata;

`ifdef MOTHERBOARD_DEBUG_EN
  assign o_debug_pc    = dbg_pc;
  assign o_debug_instr = dbg_instr;
`else
  logic unused_dbg;
  assign unused_dbg = ^{dbg_pc, dbg_instr};
`endif

endmodule

// File: tb/tb_mother_board.sv
// Directed bench for mother_board: reset release, program execution, MMIO irq, mid-run reset.
module tb_mother_board;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] i_interruption = 5'b0;
`ifdef MOTHERBOARD_DEBUG_EN
  logic [31:0] o_debug_pc, o_debug_instr;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mother_board dut (
    .clk            (clk),
    .reset          (reset),
    .i_interruption (i_interruption)
`ifdef MOTHERBOARD_DEBUG_EN
    ,
    .o_debug_pc     (o_debug_pc),
    .o_debug_instr  (o_debug_instr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] prog [21];
  logic [31:0] gpr_or;
  int          nbad;

  initial begin
    prog[0] = 32'h2001_0055;  // addi $1,$0,0x55
    prog[1] = 32'hAC01_0008;  // sw   $1,8($0)
    prog[2] = 32'h8C02_0008;  // lw   $2,8($0)
    prog[3] = 32'h2003_00AB;  // addi $3,$0,0xAB
    prog[4] = 32'hA003_000D;  // sb   $3,13($0)
    prog[5] = 32'h2004_0077;  // addi $4,$0,0x77
    prog[6] = 32'h8C04_1000;  // lw   $4,0x1000($0)
    prog[7] = 32'hAC01_1000;  // sw   $1,0x1000($0)
    prog[8] = 32'h3C06_FFFF;  // lui  $6,0xFFFF
    for (int i = 9; i < 20; i++) prog[i] = 32'h0;
    prog[20] = 32'h8CC5_0000; // lw   $5,0($6)

    for (int i = 0; i < 1024; i++) begin
      dut.imem_inst.inst_array[i] = (i < 21) ? prog[i] : 32'h0;
      dut.dmem_inst.data_array[i] = 32'h0;
    end
    dut.dmem_inst.data_array[0] = 32'hCAFE_F00D;
    dut.dmem_inst.data_array[3] = 32'h1122_3344;

    // Held in reset
    #1;
    gpr_or = 32'h0;
    for (int i = 0; i < 32; i++) gpr_or = gpr_or | dut.soc.core0.gpr_inst.array_reg[i];
    check("rst_rst_n", 32'(dut.rst_n), 32'h0);
    check("rst_pc", dut.soc.core0.pc, 32'h0);
    check("rst_exe_pc", dut.soc.core0.exe_pc_out, 32'h0);
    check("rst_exe_instr", dut.soc.core0.exe_instr, 32'h0);
    check("rst_gprs", gpr_or, 32'h0);
    check("rst_irq_sync", 32'(dut.irq_sync), 32'h0);
    #2 reset = 1'b1;

    // Release takes two edges, first EXE on the third
    tick(); check("rel_edge1", 32'(dut.rst_n), 32'h0);
    tick(); check("rel_edge2", 32'(dut.rst_n), 32'h1);
    tick(); check("exe_pc0", dut.soc.core0.exe_pc_out, 32'h0);
            check("exe_instr0", dut.soc.core0.exe_instr, 32'h2001_0055);
    tick(); check("exe_pc4", dut.soc.core0.exe_pc_out, 32'h4);
            check("sw_old_read", dut.dmem_rdata, 32'h0);
    tick(); check("exe_pc8", dut.soc.core0.exe_pc_out, 32'h8);
            check("lw_new_read", dut.dmem_rdata, 32'h55);
            check("gpr1", dut.soc.core0.gpr_inst.array_reg[1], 32'h55);

    // Interrupt line through synchronizer
    #2 i_interruption = 5'b00100;
    tick(); check("irq_edge1", 32'(dut.soc.core0.irq), 32'h0);
    tick(); check("irq_edge2", 32'(dut.soc.core0.irq), 32'h4);

    repeat (20) tick();
    check("dmem_sw", dut.dmem_inst.data_array[2], 32'h55);
    check("gpr2_lw", dut.soc.core0.gpr_inst.array_reg[2], 32'h55);
    check("dmem_sb", dut.dmem_inst.data_array[3], 32'h1122_AB44);
    check("lw_oor", dut.soc.core0.gpr_inst.array_reg[4], 32'h0);
    check("sw_oor_word0", dut.dmem_inst.data_array[0], 32'hCAFE_F00D);
    nbad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (i != 0 && i != 2 && i != 3 && dut.dmem_inst.data_array[i] != 32'h0) nbad++;
    end
    check("dmem_untouched", 32'(nbad), 32'h0);
    check("gpr6_lui", dut.soc.core0.gpr_inst.array_reg[6], 32'hFFFF_0000);
    check("mmio_irq", dut.soc.core0.gpr_inst.array_reg[5], 32'h4);

    // Mid-run reset with irq still asserted
    reset = 1'b0;
    #1;
    check("mid_rst_n", 32'(dut.rst_n), 32'h0);
    check("mid_exe_pc", dut.soc.core0.exe_pc_out, 32'h0);
    check("mid_irq_sync", 32'(dut.irq_sync), 32'h0);
    check("mid_gpr1", dut.soc.core0.gpr_inst.array_reg[1], 32'h0);
    check("mid_dmem_keep", dut.dmem_inst.data_array[2], 32'h55);
    i_interruption = 5'b0;
    #2 reset = 1'b1;
    tick(); tick();
    check("mid_rel", 32'(dut.rst_n), 32'h1);
    tick(); check("mid_exe_pc0", dut.soc.core0.exe_pc_out, 32'h0);
    tick(); check("mid_exe_pc4", dut.soc.core0.exe_pc_out, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mother_board.md
# mother_board

Board-level integration block for the single-core MIPS system. It owns instruction memory, data memory, reset conditioning and interrupt-line conditioning, and instantiates the existing CPU wrapper `soc` (pipelined core `core0`). It sits directly under the testbench/FPGA top and has no bus masters other than the core.

## Interface
- IMEM_WORDS, 1024: instruction memory depth in 32-bit words (power of two).
- DMEM_WORDS, 1024: data memory depth in 32-bit words (power of two).
- RESET_PC, 32'h0000_0000: fetch address after reset, passed to the core.
- clk  input  1  single system clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- i_interruption  input  5  external interrupt request lines, asynchronous, active-high level.
- o_debug_pc  output  32  EXE-stage PC (only with MOTHERBOARD_DEBUG_EN).
- o_debug_instr  output  32  EXE-stage instruction (only with MOTHERBOARD_DEBUG_EN).

## Operation
- Instances are named exactly `soc`, `imem_inst`, `dmem_inst`; memory arrays are `imem_inst.inst_array` and `dmem_inst.data_array` (32-bit words, index 0 upward), preloadable by `$readmemh`.
- IMEM: read-only from the core; word index = fetch_addr[log2(IMEM_WORDS)+1:2]; fetch beyond depth returns 32'h0000_0000 (NOP).
- DMEM: word index = addr[log2(DMEM_WORDS)+1:2]; 4-bit byte-enable write; read returns full word, core does byte/half extraction.
- Out-of-range data access (word index ≥ DMEM_WORDS): reads return 0, writes dropped, no exception.
- MMIO: address 32'hFFFF_0000 reads {27'b0, irq_sync}; writes there ignored.
- Reset conditioning: reset asserts internal rst_n immediately (async), deasserts through 2-flop synchronizer; rst_n drives core and interrupt logic.
- Interrupt conditioning: each bit of i_interruption passes a 2-flop synchronizer; synchronized vector irq_sync[4:0] drives the core's interrupt input as level. Core alone handles masking/priority/EPC.
- Memory contents are not cleared by reset.

## Timing
- IMEM read combinational: instruction valid same cycle as fetch address.
- DMEM read combinational; write committed at posedge when write enable high; read of same address in the same cycle returns old data, next cycle new data.
- Reset release: rst_n high 2 posedges after reset rises; first fetch at RESET_PC on the following cycle.
- During reset: irq_sync = 0, core PC = RESET_PC, all core registers 0, debug outputs 0.
- Interrupt latency: i_interruption edge visible on irq_sync after 2 posedges; pulses shorter than one clock period may be lost.
- Reset mid-operation: pipeline flushed asynchronously; in-flight DMEM write in that cycle is dropped.

## Configuration
- MOTHERBOARD_DEBUG_EN defined: o_debug_pc = core0 exe_pc_out, o_debug_instr = core0 EXE-stage instruction, both ports present.
- Not defined: both ports and their wiring absent; observability via hierarchy only (`soc.core0.exe_pc_out`, `soc.core0.gpr_inst.array_reg[i]`).

## Structure
- Shared package `mb_pkg`: address constants (MMIO_IRQ_ADDR, RESET_PC default), memory depth defaults, NOP encoding.
- Natural sub-modules: `mb_ram` (parameterized word RAM with byte enables, used for both memories, IMEM with writes tied off) and a 2-flop `mb_sync` reused for reset and interrupts.
- Core wrapper `soc` is an existing block, out of scope.

## Test plan
- Reset low 3 ns then high; IMEM[0..] loaded -> within 3 cycles EXE PC = 0x0, then 0x4, 0x8 each cycle; all 32 GPRs 0 before first writeback.
- Program `addi $1,$0,0x55; sw $1,8($0); lw $2,8($0)` -> data_array[2] = 0x55, $2 = 0x55.
- `sb` of 0xAB to address 0x0D over word 0x11223344 -> data_array[3] = 0x1122AB44.
- `lw` from 0x0000_1000 (DMEM_WORDS=1024) returns 0; `sw` there leaves all data_array unchanged.
- i_interruption = 5'b00100 held 3 cycles -> MMIO read of 0xFFFF_0000 returns 0x4; core interrupt input bit 2 high 2 cycles after assertion.
- Assert reset mid-program -> EXE PC returns to 0x0 after release, DMEM retains previously stored 0x55.
